// File: rtl/fft_spi_streamer.sv
// Snapshots the FFT result bus on start_spi and shifts all words out over an SPI master (mode, bit order, cs framing by parameter).
// Latency: cs falls one clk after accept; the frame lasts about words*(2*MSB+3)*CLK_DIV clks; done is a one-cycle pulse at the end.
// Backpressure: none. start_spi is only sampled in IDLE and ignored while busy or done. FFT_SPI_HEADER_EN adds the A5/frame-count header words.
module fft_spi_streamer #(
    parameter int N           = 16,
    parameter int MSB         = 8,
    parameter int CLK_DIV     = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int LSB_FIRST   = 0,
    parameter int CS_PER_WORD = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*2*MSB-1:0]   data_bus,
    input  logic                 start_spi,
    output logic                 busy,
    output logic                 done,
    output logic                 sclk,
    output logic                 mosi,
    output logic                 cs
);

`ifdef FFT_SPI_HEADER_EN
    localparam int HDR_WORDS = 2;
`else
    localparam int HDR_WORDS = 0;
`endif
    localparam int NW = 2*N + HDR_WORDS;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int BW = (MSB > 1) ? $clog2(MSB) : 1;
    localparam int HW = $clog2(2*MSB);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(NW-1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV-1);
    localparam logic [HW-1:0] HALF_LAST = HW'(2*MSB-1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(MSB-1);
    localparam logic          P_CPOL    = (CPOL != 0);

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SHIFT, S_TRAIL, S_GAP, S_DONE} state_t;

    state_t               r_state;
    logic [DW-1:0]        r_div;
    logic [HW-1:0]        r_half;
    logic [IW-1:0]        r_idx;
    logic [N*2*MSB-1:0]   r_snap;
    logic                 r_sclk;
    logic                 r_mosi;
    logic                 r_cs;
    logic                 r_busy;
    logic                 r_done;

    state_t               w_state_nxt;
    logic [DW-1:0]        w_div_nxt;
    logic [HW-1:0]        w_half_nxt;
    logic [IW-1:0]        w_idx_nxt;
    logic                 w_div_end;
    logic [BW-1:0]        w_k;
    logic [IW-1:0]        w_mux_idx;
    logic [BW-1:0]        w_mux_bit;
    logic [BW-1:0]        w_pos;
    logic                 w_mosi_en;
    logic [MSB-1:0]       w_word;
    logic [NW*MSB-1:0]    w_all;

`ifdef FFT_SPI_HEADER_EN
    localparam logic [MSB-1:0] HDR0 = MSB'(8'hA5);
    logic [MSB-1:0]       r_frame_cnt;
    // Header words sit below the snapshot so word 0 is H0 and word 1 is the frame count.
    assign w_all = {r_snap, r_frame_cnt, HDR0};
`else
    assign w_all = r_snap;
`endif

    assign w_div_end = (r_div == DIV_LAST);

    // Next-state and counter logic: LEAD -> SHIFT (2*MSB half periods per word) -> TRAIL -> GAP/DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_half_nxt  = r_half;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (start_spi) begin
                    w_state_nxt = S_LEAD;
                    w_div_nxt   = '0;
                    w_half_nxt  = '0;
                    w_idx_nxt   = '0;
                end
            end
            S_LEAD: begin
                if (w_div_end) begin
                    w_state_nxt = S_SHIFT;
                    w_div_nxt   = '0;
                    w_half_nxt  = '0;
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_SHIFT: begin
                if (w_div_end) begin
                    w_div_nxt = '0;
                    if (r_half == HALF_LAST) begin
                        w_half_nxt = '0;
                        // With cs held for the frame, words run back to back without leaving SHIFT.
                        if (r_idx == LAST_IDX || CS_PER_WORD != 0) begin
                            w_state_nxt = S_TRAIL;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                        end
                    end else begin
                        w_half_nxt = r_half + HW'(1);
                    end
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_TRAIL: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_GAP;
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_GAP: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_state_nxt = S_LEAD;
                    w_idx_nxt   = r_idx + IW'(1);
                end else begin
                    w_div_nxt = r_div + DW'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Pick which word/bit mosi shows next cycle. Each bit period opens with the leading edge;
    // CPHA=0 moves to the following bit at the trailing edge, CPHA=1 at the leading edge.
    always_comb begin
        w_k       = w_half_nxt[HW-1:1];
        w_mux_idx = w_idx_nxt;
        w_mux_bit = '0;
        w_mosi_en = 1'b0;
        if (w_state_nxt == S_LEAD) begin
            w_mosi_en = (CPHA == 0);
        end else if (w_state_nxt == S_SHIFT) begin
            if (CPHA != 0 || !w_half_nxt[0]) begin
                w_mosi_en = 1'b1;
                w_mux_bit = w_k;
            end else if (w_k != BIT_LAST) begin
                w_mosi_en = 1'b1;
                w_mux_bit = w_k + BW'(1);
            end else if (CS_PER_WORD == 0 && w_idx_nxt != LAST_IDX) begin
                w_mosi_en = 1'b1;
                w_mux_idx = w_idx_nxt + IW'(1);
            end
        end
        w_pos  = (LSB_FIRST != 0) ? w_mux_bit : BIT_LAST - w_mux_bit;
        w_word = '0;
        for (int i = 0; i < NW; i++) begin
            if (w_mux_idx == IW'(i)) begin
                w_word = w_all[i*MSB +: MSB];
            end
        end
    end

    // State, counters, snapshot and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_half  <= '0;
            r_idx   <= '0;
            r_snap  <= '0;
            r_sclk  <= P_CPOL;
            r_mosi  <= 1'b0;
            r_cs    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef FFT_SPI_HEADER_EN
            r_frame_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_div   <= w_div_nxt;
            r_half  <= w_half_nxt;
            r_idx   <= w_idx_nxt;
            if (r_state == S_IDLE && start_spi) begin
                r_snap <= data_bus;
            end
            // Leading edge at the start of each bit period, so sclk idles at CPOL for the
            // second half of the last bit plus TRAIL before cs rises.
            r_sclk <= (w_state_nxt == S_SHIFT) ? (w_half_nxt[0] ? P_CPOL : ~P_CPOL) : P_CPOL;
            r_mosi <= w_mosi_en & w_word[w_pos];
            r_cs   <= !(w_state_nxt == S_LEAD || w_state_nxt == S_SHIFT || w_state_nxt == S_TRAIL);
            r_busy <= (w_state_nxt == S_LEAD || w_state_nxt == S_SHIFT ||
                       w_state_nxt == S_TRAIL || w_state_nxt == S_GAP);
            r_done <= (w_state_nxt == S_DONE);
`ifdef FFT_SPI_HEADER_EN
            if (r_state == S_DONE) begin
                r_frame_cnt <= r_frame_cnt + MSB'(1);
            end
`endif
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs   = r_cs;

endmodule

// File: tb/tb_fft_spi_streamer.sv
// Directed bench for fft_spi_streamer: three instances cover modes 0/3, both bit orders,
// both cs framings and CLK_DIV 1/3; an SPI slave model decodes the pins on the falling clk edge.
module tb_fft_spi_streamer;
    localparam int N   = 4;
    localparam int MSB = 8;
`ifdef FFT_SPI_HEADER_EN
    localparam int HDR = 2;
`else
    localparam int HDR = 0;
`endif
    localparam int NWT  = 2*N + HDR;
    localparam int TOUT = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [N*2*MSB-1:0]   data_bus;
    logic [2:0]           start_v;
    wire  [2:0]           busy_v, done_v, sclk_v, mosi_v, cs_v;

    fft_spi_streamer #(.N(N), .MSB(MSB), .CLK_DIV(1), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_PER_WORD(1)) u_dut0 (
        .clk(clk), .rst(rst), .data_bus(data_bus), .start_spi(start_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]), .cs(cs_v[0]));
    fft_spi_streamer #(.N(N), .MSB(MSB), .CLK_DIV(1), .CPOL(1), .CPHA(1), .LSB_FIRST(1), .CS_PER_WORD(0)) u_dut1 (
        .clk(clk), .rst(rst), .data_bus(data_bus), .start_spi(start_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]), .cs(cs_v[1]));
    fft_spi_streamer #(.N(N), .MSB(MSB), .CLK_DIV(3), .CPOL(0), .CPHA(0), .LSB_FIRST(0), .CS_PER_WORD(1)) u_dut2 (
        .clk(clk), .rst(rst), .data_bus(data_bus), .start_spi(start_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]), .cs(cs_v[2]));

    int   div_t  [3] = '{1, 1, 3};
    logic cpol_t [3] = '{1'b0, 1'b1, 1'b0};
    logic cpha_t [3] = '{1'b0, 1'b1, 1'b0};
    logic lsb_t  [3] = '{1'b0, 1'b1, 1'b0};

    int checks   = 0;
    int failures = 0;

    // slave model state, one set per instance
    int         rx_cnt [3];
    int         bitc   [3];
    int         lead_cnt [3];
    int         csf_cnt  [3];
    int         done_cnt [3];
    int         ph_err   [3];
    int         cs_err   [3];
    int         run      [3];
    logic [7:0] sh       [3];
    logic [7:0] rx_mem   [3][16];
    logic       psclk    [3];
    logic       pcs      [3];
    logic [7:0] fc       [3];

    typedef struct {
        int         dut;
        logic [7:0] base;
        logic [7:0] step;
        int         exp_edges;
        int         exp_cs;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input int d);
        rx_cnt[d] = 0; bitc[d] = 0; lead_cnt[d] = 0; csf_cnt[d] = 0;
        done_cnt[d] = 0; ph_err[d] = 0; cs_err[d] = 0; run[d] = 1; sh[d] = '0;
    endtask

    function automatic logic [N*2*MSB-1:0] make_bus(input logic [7:0] b, input logic [7:0] s);
        logic [N*2*MSB-1:0] v;
        logic [7:0] w;
        v = '0;
        w = b;
        for (int i = 0; i < 2*N; i++) begin
            v[i*8 +: 8] = w;
            w = w + s;
        end
        return v;
    endfunction

    // SPI slave: samples pins on the falling clk edge, decodes bits on the sampling sclk edge and
    // measures every sclk/cs phase length (expected CLK_DIV, and 2*CLK_DIV from the last sclk edge to cs rise).
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            logic chs, chc;
            int   exp_run;
            chs = (sclk_v[d] !== psclk[d]);
            chc = (cs_v[d] !== pcs[d]);
            if (rst === 1'b0) begin
                if (chs) begin
                    if (sclk_v[d] == ~cpol_t[d]) lead_cnt[d]++;
                    if (sclk_v[d] == (cpol_t[d] == cpha_t[d])) begin
                        if (cs_v[d] !== 1'b0) cs_err[d]++;
                        sh[d] = lsb_t[d] ? {mosi_v[d], sh[d][7:1]} : {sh[d][6:0], mosi_v[d]};
                        bitc[d]++;
                        if (bitc[d] == 8) begin
                            if (rx_cnt[d] < 16) rx_mem[d][rx_cnt[d]] = sh[d];
                            rx_cnt[d]++;
                            bitc[d] = 0;
                        end
                    end
                end
                if (chc && cs_v[d] === 1'b0) csf_cnt[d]++;
                if (chs || chc) begin
                    exp_run = (chc && cs_v[d] === 1'b1) ? 2*div_t[d] : div_t[d];
                    if ((chs && cs_v[d] === 1'b0) || (chc && cs_v[d] === 1'b1) ||
                        (chc && cs_v[d] === 1'b0 && (rx_cnt[d] > 0 || bitc[d] > 0))) begin
                        if (run[d] != exp_run) ph_err[d]++;
                    end
                    run[d] = 1;
                end else begin
                    run[d]++;
                end
                if (done_v[d] === 1'b1) done_cnt[d]++;
            end
            psclk[d] = sclk_v[d];
            pcs[d]   = cs_v[d];
        end
    end

    task automatic wait_done(input int d, input string tag);
        int n;
        n = 0;
        while (done_v[d] !== 1'b1 && n < TOUT) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_done_seen"}, done_v[d], 1);
    endtask

    task automatic check_words(input int d, input logic [7:0] base, input logic [7:0] step, input string tag);
        logic [7:0] ew, e;
        ew = base;
        chk({tag, "_rx_cnt"}, rx_cnt[d], NWT);
        for (int i = 0; i < NWT; i++) begin
            if (i < HDR) begin
                e = (i == 0) ? 8'hA5 : fc[d];
            end else begin
                e  = ew;
                ew = ew + step;
            end
            chk($sformatf("%s_w%0d", tag, i), rx_mem[d][i], e);
        end
    endtask

    task automatic check_frame(input int d, input logic [7:0] base, input logic [7:0] step,
                               input int exp_edges, input int exp_cs, input string tag);
        data_bus = make_bus(base, step);
        clear_mon(d);
        start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        wait_done(d, tag);
        repeat (3) begin @(posedge clk); #1; end
        check_words(d, base, step, tag);
        fc[d] = fc[d] + 8'd1;
        chk({tag, "_lead_edges"}, lead_cnt[d], exp_edges);
        chk({tag, "_cs_periods"}, csf_cnt[d], exp_cs);
        chk({tag, "_done_pulses"}, done_cnt[d], 1);
        chk({tag, "_phase_err"}, ph_err[d], 0);
        chk({tag, "_cs_err"}, cs_err[d], 0);
        chk({tag, "_busy_after"}, busy_v[d], 0);
        chk({tag, "_cs_after"}, cs_v[d], 1);
        chk({tag, "_sclk_idle"}, sclk_v[d], cpol_t[d]);
    endtask

    initial begin
        int n;
        vecs[0] = '{0, 8'h10, 8'h01, NWT*8, NWT};
        vecs[1] = '{1, 8'h10, 8'h01, NWT*8, 1};
        vecs[2] = '{2, 8'h10, 8'h01, NWT*8, NWT};
        vecs[3] = '{0, 8'h5A, 8'h25, NWT*8, NWT};
        vecs[4] = '{1, 8'h80, 8'h13, NWT*8, 1};
        vecs[5] = '{2, 8'hFF, 8'hF1, NWT*8, NWT};

        rst = 1'b1; start_v = '0; data_bus = '0;
        for (int d = 0; d < 3; d++) begin
            clear_mon(d);
            fc[d] = 8'd0;
        end
        repeat (3) begin @(posedge clk); #1; end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst%0d_cs", d), cs_v[d], 1);
            chk($sformatf("rst%0d_sclk", d), sclk_v[d], cpol_t[d]);
            chk($sformatf("rst%0d_mosi", d), mosi_v[d], 0);
            chk($sformatf("rst%0d_busy", d), busy_v[d], 0);
            chk($sformatf("rst%0d_done", d), done_v[d], 0);
        end
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // start held high for the whole frame, data bus changed right after accept
        data_bus = make_bus(8'h10, 8'h01);
        clear_mon(0);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        chk("hold_busy_lead", busy_v[0], 1);
        chk("hold_cs_lead", cs_v[0], 0);
        data_bus = make_bus(8'hFF, 8'h00);
        wait_done(0, "hold1");
        chk("hold1_busy_in_done", busy_v[0], 0);
        chk("hold1_cs_in_done", cs_v[0], 1);
        check_words(0, 8'h10, 8'h01, "hold1");
        chk("hold1_cs_periods", csf_cnt[0], NWT);
        chk("hold1_lead_edges", lead_cnt[0], NWT*8);
        chk("hold1_phase_err", ph_err[0], 0);
        fc[0] = fc[0] + 8'd1;
        clear_mon(0);
        @(posedge clk); #1;
        chk("hold_idle_busy", busy_v[0], 0);
        chk("hold_idle_cs", cs_v[0], 1);
        chk("hold_idle_done", done_v[0], 0);
        @(posedge clk); #1;
        chk("hold_reaccept_busy", busy_v[0], 1);
        start_v[0] = 1'b0;
        wait_done(0, "hold2");
        repeat (3) begin @(posedge clk); #1; end
        check_words(0, 8'hFF, 8'h00, "hold2");
        fc[0] = fc[0] + 8'd1;

        // table of single frames across all three framings
        for (int k = 0; k < 6; k++) begin
            check_frame(vecs[k].dut, vecs[k].base, vecs[k].step,
                        vecs[k].exp_edges, vecs[k].exp_cs, $sformatf("v%0d", k));
        end

        // reset in the middle of word 2, bit 4
        data_bus = make_bus(8'h40, 8'h01);
        clear_mon(0);
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        n = 0;
        while (!(rx_cnt[0] == 2 && bitc[0] == 4) && n < TOUT) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_reached", (rx_cnt[0] == 2 && bitc[0] == 4), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_cs", cs_v[0], 1);
        chk("midrst_sclk", sclk_v[0], 0);
        chk("midrst_mosi", mosi_v[0], 0);
        chk("midrst_busy", busy_v[0], 0);
        chk("midrst_done", done_v[0], 0);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) fc[d] = 8'd0;
        clear_mon(0);
        repeat (20) begin @(posedge clk); #1; end
        chk("midrst_no_done", done_cnt[0], 0);
        chk("midrst_no_cs", csf_cnt[0], 0);
        chk("midrst_idle_busy", busy_v[0], 0);
        check_frame(0, 8'h40, 8'h01, NWT*8, NWT, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
